dividend_reconstructor: RTL and testbench



---
 rtl/dividend_reconstructor_pkg.sv | 16 +
 rtl/dividend_reconstructor_shift_add.sv | 67 ++++++
 rtl/dividend_reconstructor.sv | 127 ++++++++++++
 tb/tb_dividend_reconstructor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dividend_reconstructor_pkg.sv
// Shared definitions for the dividend reconstructor: FSM state encoding
// and default operand/result widths.
package recon_pkg;

    // Default operand width; the reconstructed dividend is twice as wide.
    localparam int unsigned RECON_WIDTH   = 4;
    localparam int unsigned RECON_RESULT_W = 2 * RECON_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } recon_state_t;

endpackage : recon_pkg

// File: rtl/dividend_reconstructor_shift_add.sv
// Shift-and-add datapath for the dividend reconstructor.
// Holds the 2*WIDTH accumulator, the shifted multiplicand and the bit
// counter. load starts an operation, step consumes one quotient bit
// (LSB first), add_rem folds the remainder into the accumulator.
module recon_shift_add
    import recon_pkg::*;
#(
    parameter int unsigned WIDTH = RECON_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_add_rem,
    input  logic [WIDTH-1:0]     i_quotient,
    input  logic [WIDTH-1:0]     i_divisor,
    input  logic [WIDTH-1:0]     i_remainder,
    output logic [2*WIDTH-1:0]   o_acc_next,
    output logic                 o_last_step
);

    localparam int unsigned RES_W = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [RES_W-1:0] r_acc;
    logic [RES_W-1:0] r_mcand;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic [RES_W-1:0] w_acc_next;

    // Next accumulator value: conditional partial-product add or remainder add.
    always_comb begin
        w_acc_next = r_acc;
        if (i_step && r_q[0]) begin
            w_acc_next = r_acc + r_mcand;
        end else if (i_add_rem) begin
            w_acc_next = r_acc + {{WIDTH{1'b0}}, i_remainder};
        end
    end

    // Datapath registers: load operands, then shift one quotient bit per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_acc   <= '0;
            r_mcand <= {{WIDTH{1'b0}}, i_divisor};
            r_q     <= i_quotient;
            r_cnt   <= CNT_W'(WIDTH);
        end else begin
            r_acc <= w_acc_next;
            if (i_step) begin
                r_mcand <= r_mcand << 1;
                r_q     <= r_q >> 1;
                r_cnt   <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_acc_next  = w_acc_next;
    // The step that brings the counter from 1 to 0 is the last multiply step.
    assign o_last_step = (r_cnt == CNT_W'(1));

endmodule : recon_shift_add

// File: rtl/dividend_reconstructor.sv
// Dividend reconstructor top: dividend = quotient * divisor + remainder,
// computed sequentially with valid/ready handshakes on both sides.
// Optional feature macro: RECON_CHECK_EN adds the expected/mismatch ports
// and compares the result against a latched expected dividend.
module dividend_reconstructor
    import recon_pkg::*;
#(
    parameter int unsigned WIDTH = RECON_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     quotient,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [WIDTH-1:0]     remainder,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   dividend
`ifdef RECON_CHECK_EN
    ,
    input  logic [2*WIDTH-1:0]   expected,
    output logic                 mismatch
`endif
);

    localparam int unsigned RES_W = 2 * WIDTH;

    recon_state_t     r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [RES_W-1:0] r_dividend;
    logic [WIDTH-1:0] r_rem;
`ifdef RECON_CHECK_EN
    logic [RES_W-1:0] r_expected;
    logic             r_mismatch;
`endif

    logic             w_accept;
    logic             w_step;
    logic             w_add_rem;
    logic             w_last_step;
    logic [RES_W-1:0] w_acc_next;

    assign w_accept  = in_valid && r_in_ready;
    assign w_step    = (r_state == MUL);
    assign w_add_rem = (r_state == ADD);

    recon_shift_add #(
        .WIDTH (WIDTH)
    ) u_shift_add (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_step      (w_step),
        .i_add_rem   (w_add_rem),
        .i_quotient  (quotient),
        .i_divisor   (divisor),
        .i_remainder (r_rem),
        .o_acc_next  (w_acc_next),
        .o_last_step (w_last_step)
    );

    // Control FSM with registered handshake outputs and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_dividend  <= '0;
            r_rem       <= '0;
`ifdef RECON_CHECK_EN
            r_expected  <= '0;
            r_mismatch  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rem      <= remainder;
`ifdef RECON_CHECK_EN
                        r_expected <= expected;
`endif
                        r_in_ready <= 1'b0;
                        r_state    <= MUL;
                    end
                end
                MUL: begin
                    if (w_last_step) begin
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    // Final sum is captured straight from the datapath adder so
                    // dividend and mismatch are valid in the first DONE cycle.
                    r_dividend  <= w_acc_next;
                    r_out_valid <= 1'b1;
`ifdef RECON_CHECK_EN
                    r_mismatch  <= (w_acc_next != r_expected);
`endif
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
`ifdef RECON_CHECK_EN
                        r_mismatch  <= 1'b0;
`endif
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign dividend  = r_dividend;
`ifdef RECON_CHECK_EN
    assign mismatch  = r_mismatch;
`endif

endmodule : dividend_reconstructor

// File: tb/tb_dividend_reconstructor.sv
// Directed self-checking bench for dividend_reconstructor (WIDTH=4).
// With RECON_CHECK_EN defined, the mismatch output is also checked.
module tb_dividend_reconstructor;

    localparam int unsigned W = 4;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   divisor;
    logic [W-1:0]   remainder;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] dividend;
`ifdef RECON_CHECK_EN
    logic [2*W-1:0] expected;
    logic           mismatch;
`endif

    int checks = 0;
    int errors = 0;

    dividend_reconstructor #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dividend  (dividend)
`ifdef RECON_CHECK_EN
        ,
        .expected  (expected),
        .mismatch  (mismatch)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One operation: accept, check latency cycle by cycle, optional stall with
    // ignored in_valid pulses, then handshake and check return to IDLE.
    task automatic run_op(input string tag, input logic [W-1:0] q, input logic [W-1:0] d,
                          input logic [W-1:0] r, input logic [2*W-1:0] exp_div, input int stall);
        chk({tag, "_idle_ready"}, in_ready, 1);
        in_valid  = 1'b1;
        quotient  = q;
        divisor   = d;
        remainder = r;
`ifdef RECON_CHECK_EN
        expected  = exp_div;
`endif
        @(posedge clk); #1;
        in_valid  = 1'b0;
        quotient  = '1;
        divisor   = '1;
        remainder = '1;
`ifdef RECON_CHECK_EN
        expected  = '0;
`endif
        chk({tag, "_busy_ready"}, in_ready, 0);
        for (int k = 1; k <= int'(W) + 1; k++) begin
            @(posedge clk); #1;
            chk({tag, "_latency_valid"}, out_valid, (k == int'(W) + 1) ? 1 : 0);
        end
        chk({tag, "_dividend"}, dividend, exp_div);
`ifdef RECON_CHECK_EN
        chk({tag, "_mismatch"}, mismatch, 0);
`endif
        for (int s = 0; s < stall; s++) begin
            in_valid  = (s % 2 == 0);
            quotient  = 4'd9;
            divisor   = 4'd9;
            remainder = 4'd9;
            @(posedge clk); #1;
            chk({tag, "_stall_valid"}, out_valid, 1);
            chk({tag, "_stall_dividend"}, dividend, exp_div);
            chk({tag, "_stall_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_hs_valid"}, out_valid, 0);
        chk({tag, "_hs_ready"}, in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        quotient  = '0;
        divisor   = '0;
        remainder = '0;
`ifdef RECON_CHECK_EN
        expected  = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_dividend", dividend, 0);
`ifdef RECON_CHECK_EN
        chk("reset_mismatch", mismatch, 0);
`endif

        // Basic, full-scale and zero-operand cases.
        run_op("op_3_4_1", 4'd3, 4'd4, 4'd1, 8'd13, 0);
        run_op("op_15_15_14", 4'd15, 4'd15, 4'd14, 8'd239, 0);
        run_op("op_0_9_5", 4'd0, 4'd9, 4'd5, 8'd5, 0);
        run_op("op_7_0_0", 4'd7, 4'd0, 4'd0, 8'd0, 0);

        // Stalled consumer with in_valid pulses that must be ignored.
        run_op("stall_2_5_3", 4'd2, 4'd5, 4'd3, 8'd13, 4);
        repeat (2) begin
            @(posedge clk); #1;
            chk("no_queued_valid", out_valid, 0);
            chk("no_queued_ready", in_ready, 1);
        end

        // Back-to-back with in_valid and out_ready held high: 7-cycle spacing.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        quotient  = 4'd1;
        divisor   = 4'd2;
        remainder = 4'd3;
`ifdef RECON_CHECK_EN
        expected  = 8'd5;
`endif
        @(posedge clk); #1;
        quotient  = 4'd2;
        divisor   = 4'd3;
        remainder = 4'd1;
`ifdef RECON_CHECK_EN
        expected  = 8'd7;
`endif
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            chk("b2b_first_valid", out_valid, (k == 5) ? 1 : 0);
            chk("b2b_first_ready", in_ready, (k == 6) ? 1 : 0);
            if (k == 5) chk("b2b_first_dividend", dividend, 8'd5);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_second_accept", in_ready, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_second_valid", out_valid, 1);
        chk("b2b_second_dividend", dividend, 8'd7);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_second_hs", out_valid, 0);

        // Reset in the middle of MUL discards the operation.
        in_valid  = 1'b1;
        quotient  = 4'd7;
        divisor   = 4'd7;
        remainder = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_dividend", dividend, 0);
        run_op("after_rst_1_1_0", 4'd1, 4'd1, 4'd0, 8'd1, 0);

`ifdef RECON_CHECK_EN
        // Wrong expected dividend must raise mismatch alongside out_valid.
        in_valid  = 1'b1;
        quotient  = 4'd3;
        divisor   = 4'd4;
        remainder = 4'd1;
        expected  = 8'd12;
        @(posedge clk); #1;
        in_valid = 1'b0;
        expected = 8'd13;
        repeat (5) @(posedge clk);
        #1;
        chk("mm_valid", out_valid, 1);
        chk("mm_dividend", dividend, 8'd13);
        chk("mm_flag", mismatch, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("mm_clear", mismatch, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dividend_reconstructor
